// File: rtl/period_meter_if.sv
// Measurement bus of period_meter: the raw input to be timed and the
// published {period, high_time} pair with its strobe and loss-of-signal flag.
interface period_meter_if #(
  parameter int CNT_W = 32
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             timeout;

  modport master (
    output sig_in,
    input  period,
    input  high_time,
    input  period_valid,
    input  timeout
  );

  modport slave (
    input  sig_in,
    output period,
    output high_time,
    output period_valid,
    output timeout
  );
endinterface

// File: rtl/period_meter.sv
// Times successive rising edges of a slow asynchronous square wave in clk_in
// cycles and publishes {period, high_time} with a one-cycle strobe.
module period_meter #(
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 100000000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic         clk_in,
  input  logic         reset,
  period_meter_if.slave bus
);

  typedef enum logic [0:0] {IDLE, ARMED} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE_C;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic                   s_d;
  logic                   rise_p1;
  logic                   fall_p1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] per_p2;
  logic [CNT_W-1:0] high_p2;
  logic             vld_p2;
  logic             tmo_p2;

  // p0: synchroniser chain
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.sig_in};
    end
  end

  assign s = sync_p0[SYNC_STAGES-1];

  // p1: registered edge detect
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s_d     <= 1'b0;
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
    end else begin
      s_d     <= s;
      rise_p1 <= s & ~s_d;
      fall_p1 <= ~s & s_d;
    end
  end

  // p2: measurement FSM; a rise takes priority over the timeout compare
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hcnt    <= '0;
      per_p2  <= '0;
      high_p2 <= '0;
      vld_p2  <= 1'b0;
      tmo_p2  <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_p1) begin
            cnt   <= ONE_C;
            hcnt  <= '0;
            state <= ARMED;
          end else begin
            cnt <= '0;
          end
        end
        ARMED: begin
          if (rise_p1) begin
            per_p2  <= cnt;
            high_p2 <= hcnt;
            vld_p2  <= 1'b1;
            tmo_p2  <= 1'b0;
            cnt     <= ONE_C;
            hcnt    <= '0;
          end else begin
            if (fall_p1) begin
              hcnt <= cnt;
            end
            if (cnt == TIMEOUT_C) begin
              tmo_p2 <= 1'b1;
              cnt    <= '0;
              state  <= IDLE;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p3: output registers keep the published pair and its strobe aligned
  always_ff @(posedge clk_in) begin
    if (reset) begin
      bus.period       <= '0;
      bus.high_time    <= '0;
      bus.period_valid <= 1'b0;
      bus.timeout      <= 1'b0;
    end else begin
      bus.period       <= per_p2;
      bus.high_time    <= high_p2;
      bus.period_valid <= vld_p2;
      bus.timeout      <= tmo_p2;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus pushes expected strobes, monitors
// pop and compare whenever period_valid is seen.
module tb_period_meter;

  localparam int SYNC = 2;

  typedef struct {
    longint per;
    longint high;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset_a;
  logic   reset_b;
  longint cyc = 0;
  int     compared = 0;
  int     mismatched = 0;
  exp_t   q_a[$];
  exp_t   q_b[$];
  logic   prev_a = 1'b0;
  logic   prev_b = 1'b0;

  period_meter_if #(.CNT_W(32)) bus_a ();
  period_meter_if #(.CNT_W(32)) bus_b ();

  period_meter #(.CNT_W(32), .TIMEOUT(100000), .SYNC_STAGES(SYNC)) dut_a (
    .clk_in (clk),
    .reset  (reset_a),
    .bus    (bus_a.slave)
  );

  period_meter #(.CNT_W(32), .TIMEOUT(1000), .SYNC_STAGES(SYNC)) dut_b (
    .clk_in (clk),
    .reset  (reset_b),
    .bus    (bus_b.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sig(input int which, input logic v);
    if (which == 0) bus_a.sig_in = v;
    else            bus_b.sig_in = v;
  endtask

  // One rise, hi cycles high, lo cycles low; optionally expect a strobe for it.
  task automatic pulse(input int which, input int hi, input int lo, input bit push,
                       input longint ep, input longint eh, output longint d);
    exp_t e;
    d = cyc;
    set_sig(which, 1'b1);
    if (push) begin
      e.per  = ep;
      e.high = eh;
      e.cyc  = d + SYNC + 3;
      if (which == 0) q_a.push_back(e);
      else            q_b.push_back(e);
    end
    repeat (hi) step();
    set_sig(which, 1'b0);
    repeat (lo) step();
  endtask

  task automatic restart_a(input string name);
    bus_a.sig_in = 1'b0;
    repeat (10) step();
    check(name, 64'(q_a.size()), 64'd0);
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    repeat (3) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_a.period_valid === 1'b1) begin
      check("a_b2b", {63'd0, prev_a}, 64'd0);
      if (q_a.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL a_unexpected_strobe: period %0d high_time %0d at cycle %0d, none expected",
                 bus_a.period, bus_a.high_time, cyc);
      end else begin
        e = q_a.pop_front();
        check("a_period", 64'(bus_a.period), e.per);
        check("a_high_time", 64'(bus_a.high_time), e.high);
        check("a_timeout_at_strobe", {63'd0, bus_a.timeout}, 64'd0);
        check("a_latency_cycle", cyc, e.cyc);
      end
    end
    prev_a = bus_a.period_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_b.period_valid === 1'b1) begin
      check("b_b2b", {63'd0, prev_b}, 64'd0);
      if (q_b.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL b_unexpected_strobe: period %0d high_time %0d at cycle %0d, none expected",
                 bus_b.period, bus_b.high_time, cyc);
      end else begin
        e = q_b.pop_front();
        check("b_period", 64'(bus_b.period), e.per);
        check("b_high_time", 64'(bus_b.high_time), e.high);
        check("b_timeout_at_strobe", {63'd0, bus_b.timeout}, 64'd0);
        check("b_latency_cycle", cyc, e.cyc);
      end
    end
    prev_b = bus_b.period_valid;
  end

  initial begin
    longint d;
    longint d_rel;
    longint seen;

    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.sig_in = 1'b0;
    bus_b.sig_in = 1'b0;
    repeat (3) step();
    reset_a = 1'b0;
    reset_b = 1'b0;
    step();

    check("rst_a_period", 64'(bus_a.period), 64'd0);
    check("rst_a_high_time", 64'(bus_a.high_time), 64'd0);
    check("rst_a_valid", {63'd0, bus_a.period_valid}, 64'd0);
    check("rst_a_timeout", {63'd0, bus_a.timeout}, 64'd0);
    check("rst_b_period", 64'(bus_b.period), 64'd0);
    check("rst_b_timeout", {63'd0, bus_b.timeout}, 64'd0);

    // Loss of signal on the TIMEOUT=1000 instance
    pulse(1, 4, 6, 1'b0, 0, 0, d);
    pulse(1, 4, 6, 1'b1, 10, 4, d);
    seen = -1;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (bus_b.timeout === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    check("b_timeout_cycle", seen, d + SYNC + 1003);
    check("b_period_kept", 64'(bus_b.period), 64'd10);
    check("b_high_time_kept", 64'(bus_b.high_time), 64'd4);
    step();
    pulse(1, 25, 25, 1'b0, 0, 0, d);
    check("b_timeout_held_after_rearm", {63'd0, bus_b.timeout}, 64'd1);
    pulse(1, 8, 8, 1'b1, 50, 25, d);
    repeat (8) step();
    check("b_timeout_cleared", {63'd0, bus_b.timeout}, 64'd0);
    check("b_drain", 64'(q_b.size()), 64'd0);

    // Divider output, toggling every 12500 cycles
    restart_a("a_drain_start");
    pulse(0, 12500, 12500, 1'b0, 0, 0, d);
    pulse(0, 12500, 12500, 1'b1, 25000, 12500, d);
    pulse(0, 8, 8, 1'b1, 25000, 12500, d);

    // 3 high / 7 low
    restart_a("a_drain_divider");
    pulse(0, 3, 7, 1'b0, 0, 0, d);
    for (int i = 0; i < 4; i++) pulse(0, 3, 7, 1'b1, 10, 3, d);

    // Reset midway between rises of a 100-cycle wave
    restart_a("a_drain_3_7");
    pulse(0, 50, 50, 1'b0, 0, 0, d);
    pulse(0, 50, 25, 1'b1, 100, 50, d);
    reset_a = 1'b1;
    step();
    check("mid_rst_period", 64'(bus_a.period), 64'd0);
    check("mid_rst_high_time", 64'(bus_a.high_time), 64'd0);
    check("mid_rst_valid", {63'd0, bus_a.period_valid}, 64'd0);
    check("mid_rst_timeout", {63'd0, bus_a.timeout}, 64'd0);
    reset_a = 1'b0;
    repeat (24) step();
    pulse(0, 50, 50, 1'b0, 0, 0, d);
    pulse(0, 8, 8, 1'b1, 100, 50, d);

    // Toggle every cycle: minimum period
    restart_a("a_drain_midreset");
    pulse(0, 1, 1, 1'b0, 0, 0, d);
    for (int i = 0; i < 6; i++) pulse(0, 1, 1, 1'b1, 2, 1, d);
    bus_a.sig_in = 1'b0;
    repeat (10) step();
    check("a_drain_toggle", 64'(q_a.size()), 64'd0);

    // Input held high through reset release: that rise only arms
    bus_a.sig_in = 1'b1;
    reset_a = 1'b1;
    repeat (2) step();
    reset_a = 1'b0;
    d_rel = cyc;
    repeat (5) step();
    bus_a.sig_in = 1'b0;
    repeat (20) step();
    pulse(0, 20, 20, 1'b1, 25, 5, d);
    check("arm_rise_offset", d - d_rel, 64'd25);
    for (int i = 0; i < 3; i++) pulse(0, 20, 20, 1'b1, 40, 20, d);
    pulse(0, 8, 8, 1'b1, 40, 20, d);

    repeat (10) step();
    check("a_drain_end", 64'(q_a.size()), 64'd0);
    check("b_drain_end", 64'(q_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period and high time of a slow, free-running square wave (for example a `divided_clk` from our clock dividers, or an external signal) in `clk_in` cycles.
- Synchronises the asynchronous input, detects edges and times successive rising edges.
- Publishes a consistent {period, high_time} pair with a one-cycle valid strobe.
- Flags loss of signal with a timeout. Used for on-board self-check of divider outputs and for frequency readout on the display path.

Parameters:
- `CNT_W`, 32: width of the cycle counters and measurement outputs.
- `TIMEOUT`, 100000000: cycles without a rising edge, while armed, before loss of signal is declared. Constraint: 1 < `TIMEOUT` < 2^`CNT_W`-1.
- `SYNC_STAGES`, 2: flip-flop stages in the input synchroniser, minimum 2.

Ports:
- `clk_in`  input  1: system clock; all logic on its rising edge.
- `reset`  input  1: synchronous reset, active-high.
- `sig_in`  input  1: asynchronous signal to be measured.
- `period`  output  `CNT_W`: cycles between the last two detected rising edges.
- `high_time`  output  `CNT_W`: cycles from the earlier of those rises to the intervening fall.
- `period_valid`  output  1: one-cycle strobe; `period` and `high_time` are updated in this same cycle.
- `timeout`  output  1: level flag; no rising edge within `TIMEOUT` cycles while armed.

Behaviour:
- Reset (synchronous, active-high, checked every `clk_in` edge):
  - Synchroniser flops and edge register go to 0.
  - `cnt`=0, `hcnt`=0, state=IDLE.
  - `period`=0, `high_time`=0, `period_valid`=0, `timeout`=0.
  - Reset mid-measurement discards the partial measurement.
- Synchroniser and edge detect:
  - `sig_in` passes through `SYNC_STAGES` flops to give `s`; `s_d` is `s` delayed one cycle.
  - `rise` = `s` & ~`s_d`; `fall` = ~`s` & `s_d`.
  - Because `s_d` is 0 after reset, a `sig_in` held high across reset release produces one `rise` shortly after release. That rise only arms the block and produces no measurement.
- States:
  - IDLE: `cnt` held at 0. On `rise`: set `cnt`=1, clear `hcnt`, go to ARMED. No valid strobe.
  - ARMED: `cnt` increments by 1 every cycle, saturating at all-ones.
    - On `fall`: `hcnt` <= `cnt`.
    - On `rise`: `period` <= `cnt`, `high_time` <= `hcnt`, `period_valid` <= 1, `timeout` <= 0, `cnt` <= 1, `hcnt` <= 0; stay in ARMED.
    - Else if `cnt` == `TIMEOUT`: `timeout` <= 1 and go to IDLE. `period` and `high_time` keep their last values.
- Arithmetic:
  - Rises detected at cycles t0 and t1 give `period` = t1 - t0.
  - A fall detected at tf between them gives `high_time` = tf - t0.
  - `rise` and the timeout compare in the same cycle: `rise` wins.
- Latency: `period_valid` is registered. From the first `clk_in` edge sampling `sig_in` high, the strobe appears `SYNC_STAGES`+2 cycles later.
- `period_valid` is never high for two consecutive cycles. The minimum measurable period is 2, for a `sig_in` toggling every cycle.
- `timeout` stays set through IDLE until the next successful measurement. A single rise after a timeout re-arms the block but does not clear `timeout`.
- No fall is seen between two rises only if a glitch is shorter than the synchroniser can resolve. In that case `high_time` reports 0.

Test Plan:
- Reset, then drive `sig_in` from a clock divider with `div_value`=12499 (toggle every 12500 cycles). Required response:
  - First rise: no strobe.
  - Every later rise: one-cycle `period_valid` with `period`=25000, `high_time`=12500, `timeout`=0.
- `sig_in` high 3 cycles, low 7 cycles, repeated. Required: `period`=10, `high_time`=3 on every strobe after the first. Also check the strobe lands exactly `SYNC_STAGES`+2 cycles after the sampled rising input.
- `TIMEOUT`=1000. Apply one rise, then hold low. Required:
  - `timeout` rises exactly 1000 cycles after that rise is detected.
  - No strobe; `period` and `high_time` keep their earlier values.
  - Then apply rises 50 cycles apart: the first gives no strobe, the second strobes `period`=50 and clears `timeout`.
- Assert `reset` for one cycle midway between rises of a 100-cycle wave. Required: all outputs are 0 the next cycle, the next rise only arms, and the following rise strobes `period`=100.
- `sig_in` toggles every cycle. Required: `period`=2, `high_time`=1 on each strobe, and `period_valid` is never high on consecutive cycles.
- `sig_in` held high through reset release, then low 20 cycles, then a 40-cycle wave. Required:
  - The rise shortly after release only arms the block, with no strobe.
  - The first strobe reports the time from that arming rise to the first real rise.
  - Thereafter `period`=40.
